// File: rtl/sram_req_arbiter_if.sv
// sram-like request/response channel: one requester-facing bundle carrying the
// request payload, the address handshake and the in-order read response.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Side that issues requests (a pipeline stage, or the arbiter towards the bridge).
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests (the arbiter towards a stage, or the bridge).
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between the IF-stage
// (inst) and MEM-stage (data) requesters. The grant is held across a stalled
// address handshake, the owner of every accepted transaction is queued in an
// in-order ID FIFO, and each response is steered back to its owner.
module sram_req_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_req_arbiter_if.slave    inst,
  sram_req_arbiter_if.slave    data,
  sram_req_arbiter_if.master   mem
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // Lock state: remembers who owned a request that the bridge has not yet taken.
  logic    lock_valid;
  owner_e  lock_id;

  // ID FIFO state.
  owner_e  id_mem [OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic    fifo_full;
  logic    fifo_empty;
  logic    lock_hold;
  owner_e  grantee;
  owner_e  head_id;
  logic    mem_req;
  logic    push;
  logic    pop;

  assign fifo_full  = (count == CW'(OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Grant selection: a held lock wins as long as its owner still requests;
  // otherwise data has priority over inst.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first, so no latch is inferred.
    lock_hold = 1'b0;
    grantee   = OWN_INST;
    if (lock_valid) begin
      lock_hold = (lock_id == OWN_DATA) ? data.req : inst.req;
    end
    if (lock_hold) begin
      grantee = lock_id;
    end else if (data.req) begin
      grantee = OWN_DATA;
    end
  end

  // Request issue is blocked while the FIFO is full (registered count only) or in reset.
  assign mem_req = (inst.req | data.req) & ~fifo_full & ~reset;
  assign push    = mem_req & mem.addr_ok;
  assign pop     = mem.data_ok & ~fifo_empty & ~reset;

  // Payload mux towards the bridge; everything reads 0 when no request is issued.
  always_comb begin
    mem.req   = mem_req;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.addr  = 32'd0;
    mem.wstrb = 4'd0;
    mem.wdata = 32'd0;
    if (mem_req) begin
      if (grantee == OWN_DATA) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.addr  = data.addr;
        mem.wstrb = data.wstrb;
        mem.wdata = data.wdata;
      end else begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.addr  = inst.addr;
        mem.wstrb = inst.wstrb;
        mem.wdata = inst.wdata;
      end
    end
  end

  // Handshake and response routing back to the requesters.
  always_comb begin
    inst.addr_ok = push & (grantee == OWN_INST);
    data.addr_ok = push & (grantee == OWN_DATA);
    inst.data_ok = pop & (head_id == OWN_INST);
    data.data_ok = pop & (head_id == OWN_DATA);
    inst.rdata   = reset ? 32'd0 : mem.rdata;
    data.rdata   = reset ? 32'd0 : mem.rdata;
  end

  // Lock register: set while an issued request waits for addr_ok, released on
  // the handshake or when the locked requester withdraws.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      lock_valid <= 1'b0;
      lock_id    <= OWN_INST;
    end else if (push) begin
      lock_valid <= 1'b0;
    end else if (mem_req) begin
      lock_valid <= 1'b1;
      lock_id    <= grantee;
    end else if (!lock_hold) begin
      lock_valid <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ID storage: written on accept only.
  always_ff @(posedge clk) begin
    // NOTE: the ID array is not reset; entries are only read behind a nonzero count, which reset clears.
    if (push) begin
      id_mem[wr_ptr] <= grantee;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a queue of expected owners is pushed on
// each expected accept and popped on each bridge response.
module tb_sram_req_arbiter;

  logic clk;
  logic reset;

  sram_req_arbiter_if inst_bus ();
  sram_req_arbiter_if data_bus ();
  sram_req_arbiter_if mem_bus ();

  sram_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q [$];   // expected owner per outstanding transaction: 0=inst, 1=data
  logic [31:0] resp_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.addr = 0;
    inst_bus.wstrb = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.addr = 0;
    data_bus.wstrb = 0; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drive_inst(input logic [31:0] a);
    inst_bus.req = 1; inst_bus.addr = a;
  endtask

  task automatic drive_data(input logic [31:0] a);
    data_bus.req = 1; data_bus.addr = a;
  endtask

  task automatic drive_resp(input logic [31:0] rd);
    mem_bus.data_ok = 1; mem_bus.rdata = rd; resp_val = rd;
  endtask

  // Accept expected this cycle from owner id with given address.
  task automatic expect_accept(input string tag, input bit id, input logic [31:0] a);
    check({tag, ".mem_req"}, 32'(mem_bus.req), 32'd1);
    check({tag, ".mem_addr"}, mem_bus.addr, a);
    check({tag, ".inst_addr_ok"}, 32'(inst_bus.addr_ok), 32'(!id));
    check({tag, ".data_addr_ok"}, 32'(data_bus.addr_ok), 32'(id));
    exp_q.push_back(id);
  endtask

  // Response expected this cycle; owner from the scoreboard.
  task automatic expect_resp(input string tag);
    bit id;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      id = exp_q.pop_front();
      check({tag, ".inst_data_ok"}, 32'(inst_bus.data_ok), 32'(!id));
      check({tag, ".data_data_ok"}, 32'(data_bus.data_ok), 32'(id));
      check({tag, ".inst_rdata"}, inst_bus.rdata, resp_val);
      check({tag, ".data_rdata"}, data_bus.rdata, resp_val);
    end
  endtask

  task automatic expect_no_resp(input string tag);
    check({tag, ".inst_data_ok"}, 32'(inst_bus.data_ok), 32'd0);
    check({tag, ".data_data_ok"}, 32'(data_bus.data_ok), 32'd0);
  endtask

  task automatic expect_count(input string tag);
    check({tag, ".count"}, 32'(dut.count), 32'(exp_q.size()));
  endtask

  initial begin
    idle();
    resp_val = 0;
    reset = 1;
    // Reset: drive everything high, all outputs must read 0.
    next();
    drive_inst(32'h1111_0000); drive_data(32'h2222_0000);
    mem_bus.addr_ok = 1; drive_resp(32'hffff_ffff);
    #1;
    check("rst.mem_req", 32'(mem_bus.req), 0);
    check("rst.mem_addr", mem_bus.addr, 0);
    check("rst.inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    check("rst.data_addr_ok", 32'(data_bus.addr_ok), 0);
    expect_no_resp("rst");
    check("rst.inst_rdata", inst_bus.rdata, 0);
    next();
    reset = 0; idle();
    #1; expect_count("rst");
    next();

    // 1. Single inst fetch, response two cycles later.
    drive_inst(32'h1c00_0000); mem_bus.addr_ok = 1;
    #1; expect_accept("t1.c0", 0, 32'h1c00_0000); expect_no_resp("t1.c0");
    next(); idle();
    #1; expect_no_resp("t1.c1");
    next(); drive_resp(32'h0280_0000);
    #1; expect_resp("t1.c2");
    next(); idle();
    #1; expect_no_resp("t1.c3");

    // 2. Both request: data wins, inst next cycle.
    next();
    drive_inst(32'h0000_0100); drive_data(32'h0000_0080);
    data_bus.wr = 1; data_bus.wstrb = 4'hf; data_bus.wdata = 32'hdead_beef;
    mem_bus.addr_ok = 1;
    #1; expect_accept("t2.c0", 1, 32'h80);
    check("t2.mem_wr", 32'(mem_bus.wr), 1);
    check("t2.mem_wdata", mem_bus.wdata, 32'hdead_beef);
    check("t2.mem_wstrb", 32'(mem_bus.wstrb), 32'hf);
    next(); data_bus.req = 0; data_bus.wr = 0;
    #1; expect_accept("t2.c1", 0, 32'h100);
    check("t2.mem_wr_inst", 32'(mem_bus.wr), 0);
    next(); idle(); drive_resp(32'haaaa_0001);
    #1; expect_resp("t2.r0");
    next(); drive_resp(32'haaaa_0002);
    #1; expect_resp("t2.r1");
    next(); idle();

    // 3. Inst stalls on addr_ok; data arrives later but lock keeps inst.
    drive_inst(32'h0000_0200);
    #1; check("t3.c0.mem_addr", mem_bus.addr, 32'h200);
    check("t3.c0.inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    next(); drive_data(32'h0000_0300);
    #1; check("t3.c1.mem_addr", mem_bus.addr, 32'h200);
    check("t3.c1.data_addr_ok", 32'(data_bus.addr_ok), 0);
    next();
    #1; check("t3.c2.mem_addr", mem_bus.addr, 32'h200);
    next(); mem_bus.addr_ok = 1;
    #1; expect_accept("t3.c3", 0, 32'h200);
    next(); inst_bus.req = 0;
    #1; expect_accept("t3.c4", 1, 32'h300);
    next(); idle(); drive_resp(32'hbbbb_0001);
    #1; expect_resp("t3.r0");
    next(); drive_resp(32'hbbbb_0002);
    #1; expect_resp("t3.r1");
    next(); idle();

    // 4. Fill the FIFO with alternating owners, then a blocked 5th request.
    for (int k = 0; k < 4; k++) begin
      idle(); mem_bus.addr_ok = 1;
      if (k % 2 == 0) drive_inst(32'h0000_0400 + 32'(k));
      else            drive_data(32'h0000_0400 + 32'(k));
      #1; expect_accept($sformatf("t4.acc%0d", k), bit'(k % 2), 32'h0000_0400 + 32'(k));
      next();
    end
    idle(); drive_inst(32'h0000_0500); mem_bus.addr_ok = 1;
    #1; expect_count("t4.full");
    check("t4.full.mem_req", 32'(mem_bus.req), 0);
    check("t4.full.inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    next(); drive_resp(32'hcccc_0001);
    #1; check("t4.pop.mem_req", 32'(mem_bus.req), 0);
    expect_resp("t4.rA");
    next(); mem_bus.data_ok = 0;
    #1; expect_accept("t4.fifth", 0, 32'h500);
    next(); idle();
    for (int k = 0; k < 4; k++) begin
      drive_resp(32'hcccc_0010 + 32'(k));
      #1; expect_resp($sformatf("t4.r%0d", k + 1));
      next();
    end
    idle();
    #1; expect_count("t4.drained");
    next();

    // 5. Simultaneous push and pop at count=3 across pointer wrap.
    for (int k = 0; k < 3; k++) begin
      idle(); mem_bus.addr_ok = 1;
      if (k == 1) drive_data(32'h0000_0600 + 32'(k));
      else        drive_inst(32'h0000_0600 + 32'(k));
      #1; expect_accept($sformatf("t5.acc%0d", k), bit'(k == 1), 32'h0000_0600 + 32'(k));
      next();
    end
    for (int k = 0; k < 5; k++) begin
      idle(); mem_bus.addr_ok = 1;
      if (k % 2 == 0) drive_data(32'h0000_0700 + 32'(k));
      else            drive_inst(32'h0000_0700 + 32'(k));
      drive_resp(32'hdddd_0000 + 32'(k));
      #1;
      expect_resp($sformatf("t5.pp%0d", k));
      expect_accept($sformatf("t5.pp%0d", k), bit'(k % 2 == 0), 32'h0000_0700 + 32'(k));
      next();
      idle();
      #1; expect_count($sformatf("t5.pp%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      drive_resp(32'heeee_0000 + 32'(k));
      #1; expect_resp($sformatf("t5.r%0d", k));
      next();
    end
    idle();
    #1; expect_count("t5.drained");
    // Response while empty is ignored.
    drive_resp(32'h1234_5678);
    #1; expect_no_resp("t5.empty_resp");
    next(); idle();
    #1; expect_count("t5.empty_resp");
    next();

    // 6. Reset with two outstanding, then a stray response.
    mem_bus.addr_ok = 1; drive_inst(32'h0000_0800);
    #1; expect_accept("t6.acc0", 0, 32'h800);
    next(); idle(); mem_bus.addr_ok = 1; drive_data(32'h0000_0804);
    #1; expect_accept("t6.acc1", 1, 32'h804);
    next(); idle();
    reset = 1; drive_resp(32'h5555_5555); drive_inst(32'h0000_0900); mem_bus.addr_ok = 1;
    #1; expect_no_resp("t6.rst");
    check("t6.rst.mem_req", 32'(mem_bus.req), 0);
    check("t6.rst.inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    exp_q.delete();
    next(); reset = 0; idle(); drive_resp(32'h6666_6666);
    #1; expect_no_resp("t6.stray");
    expect_count("t6.after_rst");
    next(); idle(); mem_bus.addr_ok = 1; drive_inst(32'h0000_0a00);
    #1; expect_accept("t6.new", 0, 32'ha00);
    next(); idle(); drive_resp(32'h7777_0001);
    #1; expect_resp("t6.new_r");
    next(); idle();
    #1; expect_count("t6.end");
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
